star_row_mapper: RTL and testbench
==================================

Name: star_row_mapper

Overview:
- Vertical-extent mapper that sits directly downstream of the top-level scan FSM; it consumes the goMapRows pulse and the scan position (xCount, yCount) of the bright seed pixel.
- It walks the seed column of the 160x120 image memory upward, then downward, and finds the first and last bright rows of the star.
- It returns yTop/yBottom with a one-cycle topBottomFound strobe, which the scan FSM waits on before starting the left/right mapping.

Parameters:
- xSz, 8, x coordinate width
- ySz, 7, y coordinate width
- addrSz, 15, image memory address width
- colSz, 3, pixel colour width
- THRESHOLD, 0, pixel is bright when pixVal > THRESHOLD
- MAX_Y, 120, image height in rows
- MAX_SPAN, 32, max rows probed per direction (safety bound)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- goMapRows  in  1  single-cycle start pulse
- xSeed  in  xSz  seed column, captured on go
- ySeed  in  ySz  seed row, captured on go
- pixVal  in  colSz  image memory read data; valid the cycle after rdAddr is presented
- rdReq  out  1  high while rdAddr must drive the memory
- rdAddr  out  addrSz  read address = y*160 + x
- yTop  out  ySz  topmost bright row of the star
- yBottom  out  ySz  bottommost bright row of the star
- topBottomFound  out  1  one-cycle done strobe
- busy  out  1  high from go accept until DONE, inclusive
- spanClipped  out  1  MAX_SPAN was hit in either direction; valid with done, held until next go

Behaviour:
- Reset values: all outputs 0; state IDLE; internal probe and span counters 0. Reset mid-operation aborts the scan and returns to IDLE next cycle; no done strobe is produced.
- Memory model: synchronous RAM. The address is registered at the clock edge and q is valid in the following cycle, so each probe costs 2 cycles: an ADDR cycle, then a CHK cycle.
- Probe row:
  - rdAddr is computed combinationally from (xS, yProbe) by an address translator.
  - rdReq = 1 in the UP_ADDR, UP_CHK, DN_ADDR and DN_CHK states.
- States and transitions:
  - IDLE: on goMapRows, latch xS=xSeed, yS=ySeed; set yTop=yBottom=ySeed; clear spanClipped; span=0. If ySeed==0 go to DN_SETUP, else set yProbe=ySeed-1 and go to UP_ADDR.
  - UP_ADDR: go to UP_CHK.
  - UP_CHK:
    - if pixVal>THRESHOLD: yTop=yProbe, span++.
      - if yProbe==0, go to DN_SETUP.
      - else if span==MAX_SPAN, set spanClipped and go to DN_SETUP.
      - else yProbe-- and go to UP_ADDR.
    - if dark, go to DN_SETUP.
  - DN_SETUP: span=0. If yS==MAX_Y-1 go to DONE, else set yProbe=yS+1 and go to DN_ADDR. This state is folded into the transition, not a separate cycle: the UP_CHK exit and the IDLE edge case load yProbe directly.
  - DN_ADDR: go to DN_CHK.
  - DN_CHK: mirror of UP_CHK, updating yBottom, with boundary yProbe==MAX_Y-1. Exit to DONE.
  - DONE: topBottomFound=1 for exactly this cycle; go to IDLE.
- Handshake:
  - goMapRows is ignored while busy.
  - goMapRows arriving in the same cycle as DONE is ignored; the next go must come at least one cycle later.
- The seed pixel itself is not re-read; it is bright by construction.
- Latency: go sampled at edge 0. topBottomFound is high in cycle 2*(upProbes+dnProbes), counting the cycle after edge 0 as cycle 0.
  - An up-probe that hits a dark pixel counts as a probe.
  - A skipped direction (seed on the image edge) costs 0 probes.
- Widths and arithmetic:
  - yProbe is ySz bits. Decrement is only taken when yProbe>0 and increment only when yProbe<MAX_Y-1, so no wrap can occur.
  - The span counter is clog2(MAX_SPAN)+1 bits.
- yTop, yBottom and spanClipped hold their values after DONE until the next accepted go.

Decomposition:
- Shared package holds:
  - xSz, ySz, addrSz, colSz, MAX_X=160, MAX_Y=120, THRESHOLD
  - the state encoding localparams
- The existing vga_address_translator is instantiated as the single sub-module for rdAddr.
- The top-level wrapper muxes rdAddr into the image RAM when rdReq is high; rdReq and the clean module's wrEn are mutually exclusive by FSM construction.

Test Plan:
- Seed (10,20), column 10 bright in rows 18..23 only -> yTop=18, yBottom=23; 3 up + 4 down probes; topBottomFound in cycle 14; spanClipped=0.
- Seed (0,0), rows 0..2 bright -> up skipped; yTop=0, yBottom=2; done in cycle 6.
- Seed (159,119), rows 117..119 bright -> yTop=117, yBottom=119; down skipped; done in cycle 6.
- Seed (50,60), column fully bright, MAX_SPAN=32 -> yTop=28, yBottom=92, spanClipped=1; done in cycle 128.
- Isolated single-pixel star at (5,5) -> yTop=yBottom=5; done in cycle 4. A second goMapRows pulse at cycle 2 is ignored (exactly one strobe).
- Reset asserted in cycle 3 of a scan -> next cycle busy=0, rdReq=0, yTop=yBottom=0, no strobe. A fresh go then completes normally.

Source files
------------

// File: rtl/star_row_mapper_pkg.sv
// Shared geometry, pixel threshold and FSM state encoding for the
// vertical-extent mapper and its address translator.
package star_row_mapper_pkg;

    // Coordinate / memory widths
    localparam int xSz    = 8;
    localparam int ySz    = 7;
    localparam int addrSz = 15;
    localparam int colSz  = 3;

    // Image geometry
    localparam int MAX_X = 160;
    localparam int MAX_Y = 120;

    // A pixel is bright when its value is strictly above this level
    localparam int THRESHOLD = 0;

    // Safety bound on rows probed in each direction
    localparam int MAX_SPAN = 32;
    localparam int SPAN_SZ  = $clog2(MAX_SPAN) + 1;

    // Mapper FSM states; DN_SETUP is folded into the transitions that enter it
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_UP_ADDR = 3'd1,
        ST_UP_CHK  = 3'd2,
        ST_DN_ADDR = 3'd3,
        ST_DN_CHK  = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // Brightness test applied to the RAM read data
    function automatic logic is_bright(input logic [colSz-1:0] pix);
        return (int'(pix) > THRESHOLD);
    endfunction

endpackage

// File: rtl/star_row_mapper_addr.sv
// Address translator: maps an (x, y) pixel coordinate of the 160-wide
// image onto a linear RAM address y*160 + x. Purely combinational.
module vga_address_translator
    import star_row_mapper_pkg::*;
(
    input  logic [xSz-1:0]    x_i,
    input  logic [ySz-1:0]    y_i,
    output logic [addrSz-1:0] addr_o
);

    localparam logic [addrSz-1:0] ROW_PITCH = addrSz'(MAX_X);

    logic [addrSz-1:0] x_ext;
    logic [addrSz-1:0] y_ext;

    assign x_ext = addrSz'(x_i);
    assign y_ext = addrSz'(y_i);

    // Row base plus column offset
    assign addr_o = (y_ext * ROW_PITCH) + x_ext;

endmodule

// File: rtl/star_row_mapper.sv
// Vertical-extent mapper. Starting from a bright seed pixel, walks the
// seed column upward and then downward through a synchronous image RAM
// (one ADDR cycle plus one CHK cycle per probed row) and reports the first
// and last bright rows of the star with a single-cycle done strobe.
module star_row_mapper
    import star_row_mapper_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              goMapRows,
    input  logic [xSz-1:0]    xSeed,
    input  logic [ySz-1:0]    ySeed,
    input  logic [colSz-1:0]  pixVal,
    output logic              rdReq,
    output logic [addrSz-1:0] rdAddr,
    output logic [ySz-1:0]    yTop,
    output logic [ySz-1:0]    yBottom,
    output logic              topBottomFound,
    output logic              busy,
    output logic              spanClipped
);

    localparam logic [ySz-1:0]     Y_FIRST    = '0;
    localparam logic [ySz-1:0]     Y_LAST     = ySz'(MAX_Y - 1);
    localparam logic [ySz-1:0]     Y_ONE      = ySz'(1);
    localparam logic [SPAN_SZ-1:0] SPAN_LIMIT = SPAN_SZ'(MAX_SPAN);
    localparam logic [SPAN_SZ-1:0] SPAN_ONE   = SPAN_SZ'(1);

    state_e              state_q,  state_d;
    logic [xSz-1:0]      xs_q,     xs_d;
    logic [ySz-1:0]      ys_q,     ys_d;
    logic [ySz-1:0]      yprobe_q, yprobe_d;
    logic [SPAN_SZ-1:0]  span_q,   span_d;
    logic [ySz-1:0]      ytop_q,   ytop_d;
    logic [ySz-1:0]      ybot_q,   ybot_d;
    logic                clip_q,   clip_d;

    logic [SPAN_SZ-1:0]  span_inc;
    logic                pix_bright;

    assign span_inc   = span_q + SPAN_ONE;
    assign pix_bright = is_bright(pixVal);

    // Probe row -> RAM address
    vga_address_translator u_addr (
        .x_i    (xs_q),
        .y_i    (yprobe_q),
        .addr_o (rdAddr)
    );

    // State and datapath registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            xs_q     <= '0;
            ys_q     <= '0;
            yprobe_q <= '0;
            span_q   <= '0;
            ytop_q   <= '0;
            ybot_q   <= '0;
            clip_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            xs_q     <= xs_d;
            ys_q     <= ys_d;
            yprobe_q <= yprobe_d;
            span_q   <= span_d;
            ytop_q   <= ytop_d;
            ybot_q   <= ybot_d;
            clip_q   <= clip_d;
        end
    end

    // Next-state logic: upward walk, then downward walk, then done
    always_comb begin
        state_d  = state_q;
        xs_d     = xs_q;
        ys_d     = ys_q;
        yprobe_d = yprobe_q;
        span_d   = span_q;
        ytop_d   = ytop_q;
        ybot_d   = ybot_q;
        clip_d   = clip_q;

        unique case (state_q)
            ST_IDLE: begin
                if (goMapRows) begin
                    xs_d   = xSeed;
                    ys_d   = ySeed;
                    ytop_d = ySeed;
                    ybot_d = ySeed;
                    clip_d = 1'b0;
                    span_d = '0;
                    if (ySeed == Y_FIRST) begin
                        // Seed on the top edge: skip straight to the downward walk
                        if (ySeed >= Y_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            yprobe_d = ySeed + Y_ONE;
                            state_d  = ST_DN_ADDR;
                        end
                    end else begin
                        yprobe_d = ySeed - Y_ONE;
                        state_d  = ST_UP_ADDR;
                    end
                end
            end

            ST_UP_ADDR: begin
                state_d = ST_UP_CHK;
            end

            ST_UP_CHK: begin
                // Any exit from the upward walk enters the downward setup
                span_d = '0;
                if (ys_q >= Y_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    yprobe_d = ys_q + Y_ONE;
                    state_d  = ST_DN_ADDR;
                end
                if (pix_bright) begin
                    ytop_d = yprobe_q;
                    if (yprobe_q == Y_FIRST) begin
                        // top image edge reached; downward setup already chosen
                    end else if (span_inc == SPAN_LIMIT) begin
                        clip_d = 1'b1;
                    end else begin
                        span_d   = span_inc;
                        yprobe_d = yprobe_q - Y_ONE;
                        state_d  = ST_UP_ADDR;
                    end
                end
            end

            ST_DN_ADDR: begin
                state_d = ST_DN_CHK;
            end

            ST_DN_CHK: begin
                state_d = ST_DONE;
                if (pix_bright) begin
                    ybot_d = yprobe_q;
                    span_d = span_inc;
                    if (yprobe_q >= Y_LAST) begin
                        state_d = ST_DONE;
                    end else if (span_inc == SPAN_LIMIT) begin
                        clip_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        yprobe_d = yprobe_q + Y_ONE;
                        state_d  = ST_DN_ADDR;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state
    always_comb begin
        rdReq          = (state_q == ST_UP_ADDR) || (state_q == ST_UP_CHK) ||
                         (state_q == ST_DN_ADDR) || (state_q == ST_DN_CHK);
        topBottomFound = (state_q == ST_DONE);
        busy           = (state_q != ST_IDLE);
        yTop           = ytop_q;
        yBottom        = ybot_q;
        spanClipped    = clip_q;
    end

endmodule

// File: tb/tb_star_row_mapper.sv
// Scoreboard bench for star_row_mapper: a synchronous image RAM model,
// a row-walk reference model, a go driver and an independent done monitor.
module tb_star_row_mapper;
    import star_row_mapper_pkg::*;

    localparam int NPIX = MAX_X * MAX_Y;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              goMapRows = 1'b0;
    logic [xSz-1:0]    xSeed = '0;
    logic [ySz-1:0]    ySeed = '0;
    logic [colSz-1:0]  pixVal = '0;
    logic              rdReq;
    logic [addrSz-1:0] rdAddr;
    logic [ySz-1:0]    yTop;
    logic [ySz-1:0]    yBottom;
    logic              topBottomFound;
    logic              busy;
    logic              spanClipped;

    star_row_mapper dut (
        .clk            (clk),
        .reset          (reset),
        .goMapRows      (goMapRows),
        .xSeed          (xSeed),
        .ySeed          (ySeed),
        .pixVal         (pixVal),
        .rdReq          (rdReq),
        .rdAddr         (rdAddr),
        .yTop           (yTop),
        .yBottom        (yBottom),
        .topBottomFound (topBottomFound),
        .busy           (busy),
        .spanClipped    (spanClipped)
    );

    always #5 clk = ~clk;

    // Image RAM: address registered, data valid the following cycle
    logic [colSz-1:0] img [0:NPIX-1];
    always @(posedge clk)
        pixVal <= (rdReq && int'(rdAddr) < NPIX) ? img[rdAddr] : '0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int top;
        int bot;
        int clip;
        int done_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;
    int strobes = 0;
    int expected_strobes = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit bright(input int x, input int y);
        return int'(img[y * MAX_X + x]) > THRESHOLD;
    endfunction

    // Reference: walk the column in each direction following the probing rules
    function automatic void model(input int x, input int y,
                                  output int top, output int bot,
                                  output int clip, output int probes);
        int span;
        top = y; bot = y; clip = 0; probes = 0;
        span = 0;
        for (int r = y - 1; r >= 0; r--) begin
            probes++;
            if (!bright(x, r)) break;
            top = r;
            span++;
            if (r == 0) break;
            if (span == MAX_SPAN) begin clip = 1; break; end
        end
        span = 0;
        for (int r = y + 1; r <= MAX_Y - 1; r++) begin
            probes++;
            if (!bright(x, r)) break;
            bot = r;
            span++;
            if (r == MAX_Y - 1) break;
            if (span == MAX_SPAN) begin clip = 1; break; end
        end
    endfunction

    // Monitor: every done strobe is matched against the scoreboard head
    always @(negedge clk) begin
        if (topBottomFound) begin
            strobes++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("yTop", int'(yTop), mon_e.top);
                check("yBottom", int'(yBottom), mon_e.bot);
                check("spanClipped", int'(spanClipped), mon_e.clip);
                check("done_cycle", cyc, mon_e.done_cyc);
                $display("scan done: yTop=%0d yBottom=%0d clip=%0d cycle=%0d",
                         yTop, yBottom, spanClipped, cyc);
            end
        end
    end

    task automatic clear_col(input int x);
        for (int r = 0; r < MAX_Y; r++) img[r * MAX_X + x] = '0;
    endtask

    task automatic set_rows(input int x, input int r0, input int r1);
        for (int r = r0; r <= r1; r++) img[r * MAX_X + x] = colSz'($urandom_range(1, 7));
    endtask

    // Pulse go for one cycle; returns cyc as seen during cycle 0
    task automatic issue(input int x, input int y, output int c0);
        logic [xSz-1:0] xv;
        logic [ySz-1:0] yv;
        xv = xSz'(x);
        yv = ySz'(y);
        @(negedge clk);
        goMapRows = 1'b1;
        xSeed = xv;
        ySeed = yv;
        @(negedge clk);
        goMapRows = 1'b0;
        c0 = cyc;
    endtask

    task automatic push_exp(input int x, input int y, input int c0);
        int t, b, cl, p;
        exp_t e;
        model(x, y, t, b, cl, p);
        e.top = t; e.bot = b; e.clip = cl; e.done_cyc = c0 + 2 * p;
        sb.push_back(e);
        expected_strobes++;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("busy_timeout", int'(busy), 0);
    endtask

    task automatic scan(input int x, input int y);
        int c0;
        issue(x, y, c0);
        push_exp(x, y, c0);
        wait_idle();
    endtask

    initial begin
        int c0;
        int x, y, thr;
        for (int i = 0; i < NPIX; i++) img[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_rdReq", int'(rdReq), 0);
        check("rst_done", int'(topBottomFound), 0);
        check("rst_yTop", int'(yTop), 0);
        check("rst_yBottom", int'(yBottom), 0);
        check("rst_clip", int'(spanClipped), 0);
        reset = 1'b0;
        @(negedge clk);

        // Seed (10,20), rows 18..23 bright
        clear_col(10); set_rows(10, 18, 23);
        scan(10, 20);

        // Seed (0,0), rows 0..2: upward walk skipped
        clear_col(0); set_rows(0, 0, 2);
        scan(0, 0);

        // Seed (159,119), rows 117..119: downward walk skipped
        clear_col(159); set_rows(159, 117, 119);
        scan(159, 119);

        // Isolated pixel at (5,5), with a stray go during the scan
        clear_col(5); set_rows(5, 5, 5);
        issue(5, 5, c0);
        push_exp(5, 5, c0);
        @(negedge clk);
        @(negedge clk);
        goMapRows = 1'b1; xSeed = 8'd10; ySeed = 7'd20;
        @(negedge clk);
        goMapRows = 1'b0;
        wait_idle();

        // Fully bright column: both walks clipped
        clear_col(50); set_rows(50, 0, MAX_Y - 1);
        scan(50, 60);

        // Reset in cycle 3 of a scan aborts it without a strobe
        issue(10, 20, c0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_rdReq", int'(rdReq), 0);
        check("abort_yTop", int'(yTop), 0);
        check("abort_yBottom", int'(yBottom), 0);
        check("abort_clip", int'(spanClipped), 0);
        repeat (20) @(negedge clk);
        scan(10, 20);

        // Randomized columns with varying bright density
        for (int k = 0; k < 24; k++) begin
            x = int'($urandom_range(0, MAX_X - 1));
            y = int'($urandom_range(0, MAX_Y - 1));
            thr = int'($urandom_range(0, 8));
            clear_col(x);
            for (int r = 0; r < MAX_Y; r++)
                if (int'($urandom_range(0, 7)) < thr) set_rows(x, r, r);
            set_rows(x, y, y);
            @(negedge clk);
            scan(x, y);
        end

        repeat (5) @(negedge clk);
        check("strobe_count", strobes, expected_strobes);
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
